mux_nto1_pipe: RTL and testbench

Parametrised N-to-1 selector with a registered, elastic output stage and valid/ready handshake on both sides. Generalises the 16-bit 2-to-1 mux used for PC-in, memory-out and ALU-operand selection into a pipelined selector. It is placed between pipeline stages so that select decode and the following stage are timing-isolated and back-pressure is absorbed without data loss. It carries the select tag forward, reports out-of-range selects, and supports a synchronous flush for branch/exception squash.

---
 rtl/mux_nto1_pipe.sv | 116 +++++++++++
 tb/tb_mux_nto1_pipe.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_nto1_pipe.sv
// N-to-1 selector with registered output and valid/ready on both sides; optional skid stage via MUX_SKID_EN.
// Latency: an entry accepted at edge t is presented on out_data/out_sel with out_valid=1 in cycle t+1.
// Backpressure: with MUX_SKID_EN in_ready is registered (!skid_valid); without it in_ready = !out_valid | out_ready.
module mux_nto1_pipe #(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  parameter int SELW  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SELW-1:0]    sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               sel_err
);

  logic             accept;
  logic             in_range;
  logic [WIDTH-1:0] cap_data;

  assign accept = in_valid & in_ready;

  // Out-of-range selects fall through with zero data and in_range low.
  always_comb begin
    cap_data = '0;
    in_range = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (sel == SELW'(k)) begin
        cap_data = in_data[k*WIDTH +: WIDTH];
        in_range = 1'b1;
      end
    end
  end

`ifdef MUX_SKID_EN
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic [SELW-1:0]  skid_sel;

  assign in_ready = !skid_valid;

  // Skid is only ever occupied while main is full, so a freeing main always prefers skid.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid || out_ready) begin
      out_valid  <= skid_valid | accept;
      skid_valid <= 1'b0;
    end else if (accept) begin
      skid_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
      out_sel  <= '0;
    end else if (!flush && (!out_valid || out_ready)) begin
      if (skid_valid) begin
        out_data <= skid_data;
        out_sel  <= skid_sel;
      end else if (accept) begin
        out_data <= cap_data;
        out_sel  <= sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_data <= '0;
      skid_sel  <= '0;
    end else if (!flush && out_valid && !out_ready && accept) begin
      skid_data <= cap_data;
      skid_sel  <= sel;
    end
  end
`else
  assign in_ready = !out_valid | out_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_valid <= 1'b0;
    end else if (in_ready) begin
      out_valid <= accept;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
      out_sel  <= '0;
    end else if (!flush && accept) begin
      out_data <= cap_data;
      out_sel  <= sel;
    end
  end
`endif

  // A flushed accept is discarded entirely, so it does not raise the error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_err <= 1'b0;
    end else if (accept && !flush && !in_range) begin
      sel_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Bench for mux_nto1_pipe: N=4 instance under a queue scoreboard, N=3 instance for out-of-range selects.
module tb_mux_nto1_pipe;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [63:0] in_data;
  logic [1:0]  sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic [1:0]  out_sel;
  logic        out_valid;
  logic        out_ready;
  logic        sel_err;

  logic        d3_flush;
  logic [47:0] d3_in_data;
  logic [1:0]  d3_sel;
  logic        d3_in_valid;
  logic        d3_in_ready;
  logic [15:0] d3_out_data;
  logic [1:0]  d3_out_sel;
  logic        d3_out_valid;
  logic        d3_out_ready;
  logic        d3_sel_err;

  mux_nto1_pipe #(.WIDTH(16), .N(4), .SELW(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_sel(out_sel),
    .out_valid(out_valid), .out_ready(out_ready), .sel_err(sel_err)
  );

  mux_nto1_pipe #(.WIDTH(16), .N(3), .SELW(2)) dut3 (
    .clk(clk), .rst(rst), .flush(d3_flush), .in_data(d3_in_data), .sel(d3_sel),
    .in_valid(d3_in_valid), .in_ready(d3_in_ready), .out_data(d3_out_data), .out_sel(d3_out_sel),
    .out_valid(d3_out_valid), .out_ready(d3_out_ready), .sel_err(d3_sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] pick(input logic [63:0] ch, input logic [1:0] s);
    logic [63:0] t;
    t = ch >> (16 * s);
    return t[15:0];
  endfunction

  // Reference: the block is a FIFO of depth 2 (skid) or 1, fed by accepts and drained by transfers.
  typedef struct packed {
    logic [15:0] d;
    logic [1:0]  s;
  } ent_t;

  ent_t q[$];
  bit   mon_on = 1'b0;
  int   n_acc = 0;
  int   n_out = 0;

  always @(negedge clk) begin
    if (mon_on) begin
      ent_t e;
      chk("occ_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
`ifdef MUX_SKID_EN
      chk("ready_occ", {31'b0, in_ready}, {31'b0, q.size() < 2});
`else
      chk("ready_occ", {31'b0, in_ready}, {31'b0, (q.size() == 0) || out_ready});
`endif
      if (out_valid && out_ready && q.size() > 0) begin
        e = q.pop_front();
        chk("sb_data", {16'b0, out_data}, {16'b0, e.d});
        chk("sb_sel", {30'b0, out_sel}, {30'b0, e.s});
        n_out++;
      end
      if (rst || flush) begin
        q.delete();
      end else if (in_valid && in_ready) begin
        q.push_back({pick(in_data, sel), sel});
        n_acc++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end

  typedef struct {
    logic [63:0] ch;
    logic [1:0]  s;
    logic [15:0] exp;
  } vec_t;

  localparam logic [63:0] CH = 64'h4444_3333_2222_1111;

  initial begin
    vec_t        tbl[5];
    logic [15:0] got[4];
    logic [15:0] bp_exp[4];
    int          idx;
    int          n;
    int          a0;
    int          o0;
    logic [1:0]  last_s;

    tbl[0] = '{CH, 2'd2, 16'h3333};
    tbl[1] = '{CH, 2'd0, 16'h1111};
    tbl[2] = '{CH, 2'd3, 16'h4444};
    tbl[3] = '{64'hDEAD_BEEF_0123_ABCD, 2'd1, 16'h0123};
    tbl[4] = '{64'h0000_FFFF_8000_0001, 2'd2, 16'hFFFF};
    bp_exp[0] = 16'h1111; bp_exp[1] = 16'h2222; bp_exp[2] = 16'h3333; bp_exp[3] = 16'h4444;
    for (int i = 0; i < 4; i++) got[i] = '0;

    rst = 1'b1; flush = 1'b0; in_data = '0; sel = '0; in_valid = 1'b0; out_ready = 1'b0;
    d3_flush = 1'b0; d3_in_data = '0; d3_sel = '0; d3_in_valid = 1'b0; d3_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_on = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_out_data", {16'b0, out_data}, 0);
    chk("rst_out_sel", {30'b0, out_sel}, 0);
    chk("rst_sel_err", {31'b0, sel_err}, 0);
    chk("rst_in_ready", {31'b0, in_ready}, 1);
    chk("rst_d3_ready", {31'b0, d3_in_ready}, 1);

    // Table: one accept, then the registered result one cycle later
    for (int i = 0; i < 5; i++) begin
      tick();
      in_data = tbl[i].ch; sel = tbl[i].s; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk("tbl_valid", {31'b0, out_valid}, 1);
      chk("tbl_data", {16'b0, out_data}, {16'b0, tbl[i].exp});
      chk("tbl_sel", {30'b0, out_sel}, {30'b0, tbl[i].s});
    end

    // Back-pressure: offer sel 0..3 with the output stalled for 3 cycles
    tick();
    in_data = CH; out_ready = 1'b0; idx = 0;
    for (int c = 0; c < 3; c++) begin
      sel = idx[1:0]; in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) idx++;
      if (out_valid) chk("stall_data", {16'b0, out_data}, 32'h1111);
      tick();
    end
`ifdef MUX_SKID_EN
    chk("bp_accepts", idx, 2);
`else
    chk("bp_accepts", idx, 1);
`endif
    chk("bp_ready_low", {31'b0, in_ready}, 0);
    out_ready = 1'b1; n = 0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      in_valid = (idx < 4);
      sel = idx[1:0];
      @(negedge clk);
      if (out_valid) begin
        got[n] = out_data;
        n++;
      end
      if (in_valid && in_ready) idx++;
      tick();
    end
    in_valid = 1'b0;
    chk("bp_count", n, 4);
    for (int k = 0; k < 4; k++) chk("bp_order", {16'b0, got[k]}, {16'b0, bp_exp[k]});
    tick();

    // Flush with buffered entries and a same-cycle offer
    out_ready = 1'b0; in_data = CH;
    for (int c = 0; c < 2; c++) begin
      sel = 2'(c); in_valid = 1'b1;
      tick();
    end
    flush = 1'b1; sel = 2'd3; in_valid = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_valid", {31'b0, out_valid}, 0);
    chk("flush_ready", {31'b0, in_ready}, 1);
    tick();
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("flush_no_ghost", {31'b0, out_valid}, 0);

    // Out-of-range select on the N=3 instance, then 10 valid accepts
    tick();
    d3_in_data = {16'h3333, 16'h2222, 16'h1111};
    d3_sel = 2'd3; d3_in_valid = 1'b1; d3_out_ready = 1'b1;
    tick();
    d3_in_valid = 1'b0;
    @(negedge clk);
    chk("oor_valid", {31'b0, d3_out_valid}, 1);
    chk("oor_data", {16'b0, d3_out_data}, 0);
    chk("oor_sel", {30'b0, d3_out_sel}, 3);
    chk("oor_err", {31'b0, d3_sel_err}, 1);
    last_s = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      last_s = 2'($urandom_range(0, 2));
      d3_sel = last_s; d3_in_valid = 1'b1;
    end
    tick();
    d3_in_valid = 1'b0;
    @(negedge clk);
    chk("oor_err_sticky", {31'b0, d3_sel_err}, 1);
    chk("oor_last_data", {16'b0, d3_out_data}, {16'b0, 16'h1111 * (16'(last_s) + 16'd1)});

    // Reset while the main instance is full
    tick();
    out_ready = 1'b0; in_data = CH;
    for (int c = 0; c < 3; c++) begin
      sel = 2'(c + 1); in_valid = 1'b1;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("mrst_valid", {31'b0, out_valid}, 0);
    chk("mrst_data", {16'b0, out_data}, 0);
    chk("mrst_ready", {31'b0, in_ready}, 1);
    chk("mrst_d3_err", {31'b0, d3_sel_err}, 0);

    // Full throughput: 100 back-to-back accepts with out_ready held high
    tick();
    out_ready = 1'b1;
    a0 = n_acc; o0 = n_out;
    for (int i = 0; i < 100; i++) begin
      in_data = {$urandom, $urandom}; sel = 2'($urandom); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("tput_acc", n_acc - a0, 100);
    chk("tput_out_inflight", n_out - o0, 99);
    tick();
    chk("tput_out", n_out - o0, 100);

    // Random traffic with random stalls and occasional flush
    for (int i = 0; i < 400; i++) begin
      in_data = {$urandom, $urandom}; sel = 2'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 39) == 0);
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (4) tick();
    chk("drain_empty", q.size(), 0);
    chk("drain_valid", {31'b0, out_valid}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
